// File: rtl/axi_inter_rr_mux_if.sv
// Handshake bundle for axi_inter_rr_mux.
//   in_valid/in_ready/in_data/in_last : one beat channel per source (M = 2**IN_WIDTH)
//   out_valid/out_ready/out_data/out_last/out_sel : merged destination channel
//   busy : high while a source holds the grant
// master modport: the side driving sources and the destination ready.
// slave modport : the multiplexer itself.
interface axi_inter_rr_mux_if #(
    parameter int unsigned IN_WIDTH = 2,
    parameter int unsigned N        = 32
);
    localparam int unsigned M = 2 ** IN_WIDTH;

    logic [M-1:0]        in_valid;
    logic [M-1:0]        in_ready;
    logic [N-1:0]        in_data [M];
    logic [M-1:0]        in_last;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        out_data;
    logic                out_last;
    logic [IN_WIDTH-1:0] out_sel;
    logic                busy;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel, busy
    );
endinterface

// File: rtl/axi_inter_rr_mux.sv
// M:1 channel multiplexer with round-robin arbitration and a registered output stage.
// A granted source keeps the grant until its last beat is accepted (or for a single beat
// when LOCK_ON_LAST=0); one IDLE arbitration cycle separates consecutive bursts.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : axi_inter_rr_mux_if.slave (sources in, merged destination out, busy)
module axi_inter_rr_mux #(
    parameter int unsigned IN_WIDTH     = 2,
    parameter int unsigned N            = 32,
    parameter bit          LOCK_ON_LAST = 1'b1
) (
    input logic               clk,
    input logic               rst,
    axi_inter_rr_mux_if.slave bus
);
    localparam int unsigned M = 2 ** IN_WIDTH;

    typedef enum logic {StIdle, StLocked} state_e;

    state_e              r_state;
    logic [IN_WIDTH-1:0] r_ptr;
    logic [IN_WIDTH-1:0] r_grant;
    logic                r_out_valid;
    logic [N-1:0]        r_out_data;
    logic                r_out_last;
    logic [IN_WIDTH-1:0] r_out_sel;

    logic                w_found;
    logic [IN_WIDTH-1:0] w_pick;
    logic                w_grant_ready;
    logic                w_accept;
    logic                w_release;

    // First requester at or above r_ptr; the index wraps by its own width.
    always_comb begin : arbitrate
        logic [IN_WIDTH-1:0] idx;
        w_found = 1'b0;
        w_pick  = r_ptr;
        idx     = r_ptr;
        for (int unsigned i = 0; i < M; i++) begin
            idx = r_ptr + IN_WIDTH'(i);
            if (!w_found && bus.in_valid[idx]) begin
                w_found = 1'b1;
                w_pick  = idx;
            end
        end
    end

    // The output register can take a new beat when empty or draining this cycle.
    assign w_grant_ready = !r_out_valid || bus.out_ready;
    assign w_accept      = (r_state == StLocked) && bus.in_valid[r_grant] && w_grant_ready;
    assign w_release     = w_accept && (bus.in_last[r_grant] || !LOCK_ON_LAST);

    always_comb begin
        bus.in_ready = '0;
        if (r_state == StLocked) begin
            bus.in_ready[r_grant] = w_grant_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_state <= StLocked;
                    end
                end
                StLocked: begin
                    if (w_release) begin
                        r_state <= StIdle;
                        r_ptr   <= r_grant + IN_WIDTH'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= bus.in_data[r_grant];
                r_out_last  <= bus.in_last[r_grant];
                r_out_sel   <= r_grant;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_sel   = r_out_sel;
    assign bus.busy      = (r_state == StLocked);
endmodule
